// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps each instruction through fetch/decode/execute/memory/writeback
// and drives datapath selects, write enables and ALU operation from the registered state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP_code,
  input  logic [5:0] FUNC_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       mem_byte,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDest,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [1:0] PCSource,
  output logic [3:0] ALU_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    JR        = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20, OP_LW    = 6'h23, OP_SB   = 6'h28, OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t state_q, state_d;

  // Supported R-type function codes (jr is handled separately in DECODE).
  function automatic logic r_legal(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23,
      6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: r_legal = 1'b1;
      default:                           r_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
    case (fn)
      6'h24:        r_alu_op = 4'd1;
      6'h25:        r_alu_op = 4'd2;
      6'h00:        r_alu_op = 4'd3;
      6'h02:        r_alu_op = 4'd4;
      6'h2A:        r_alu_op = 4'd5;
      6'h22, 6'h23: r_alu_op = 4'd6;
      6'h27:        r_alu_op = 4'd10;
      6'h26:        r_alu_op = 4'd11;
      default:      r_alu_op = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Outputs and next state; everything is held at 0 while rst is high so no write can leak.
  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    mem_byte   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDest    = 2'd0;
    MemtoReg   = 2'd0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'd0;
    ExtZero    = 1'b0;
    PCSource   = 2'd0;
    ALU_op     = 4'd0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'd3;
          case (OP_code)
            OP_LW, OP_LB, OP_SW, OP_SB: state_d = MEM_ADDR;
            OP_RTYPE: begin
              if (FUNC_code == FN_JR)      state_d = JR;
              else if (r_legal(FUNC_code)) state_d = R_EXEC;
              else begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
              end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI, OP_SLTIU: state_d = I_EXEC;
            OP_BEQ, OP_BNE:             state_d = BRANCH;
            OP_J, OP_JAL:               state_d = JUMP;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          state_d = (OP_code == OP_LW || OP_code == OP_LB) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          MemRead  = 1'b1;
          IorD     = 1'b1;
          mem_byte = (OP_code == OP_LB);
          state_d  = mem_ready ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 2'd1;
          instr_done = 1'b1;
        end
        MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          mem_byte   = (OP_code == OP_SB);
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEM_WRITE;
        end
        R_EXEC: begin
          ALUSrcA = 1'b1;
          ALU_op  = r_alu_op(FUNC_code);
          state_d = R_WB;
        end
        R_WB: begin
          RegWrite   = 1'b1;
          RegDest    = 2'd1;
          instr_done = 1'b1;
        end
        I_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          case (OP_code)
            OP_ANDI:            begin ALU_op = 4'd1;  ExtZero = 1'b1; end
            OP_ORI:             begin ALU_op = 4'd2;  ExtZero = 1'b1; end
            OP_XORI:            begin ALU_op = 4'd11; ExtZero = 1'b1; end
            OP_SLTI, OP_SLTIU:  ALU_op = 4'd5;
            default:            ALU_op = 4'd0;
          endcase
          state_d = I_WB;
        end
        I_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 1'b1;
          PCSource   = 2'd1;
          instr_done = 1'b1;
          if (OP_code == OP_BNE) begin
            ALU_op  = 4'd8;
            PCWrite = ~zero;
          end else begin
            ALU_op  = 4'd9;
            PCWrite = zero;
          end
        end
        JUMP: begin
          PCSource   = 2'd2;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          if (OP_code == OP_JAL) begin
            RegWrite = 1'b1;
            RegDest  = 2'd2;
            MemtoReg = 2'd2;
          end
        end
        JR: begin
          ALUSrcA    = 1'b1;
          PCSource   = 2'd3;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction classes cycle by cycle with hand-derived expectations.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OP_code, FUNC_code;
  logic       zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, mem_byte, IRWrite, RegWrite;
  logic [1:0] RegDest, MemtoReg, ALUSrcB, PCSource;
  logic       ALUSrcA, ExtZero, instr_done, illegal_op;
  logic [3:0] ALU_op, state;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .OP_code(OP_code), .FUNC_code(FUNC_code), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_byte(mem_byte), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDest(RegDest), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtZero(ExtZero), .PCSource(PCSource), .ALU_op(ALU_op), .instr_done(instr_done),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic z);
    OP_code   = op;
    FUNC_code = fn;
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  // Run an R-type ALU instruction (mem_ready high) and check the ALU_op chosen in R_EXEC.
  task automatic run_r(input logic [5:0] fn, input int exp_op);
    drive(6'h00, fn, 1'b1, 1'b0); tick;
    chk("r_dec_state", state, 1); tick;
    chk("r_exec_state", state, 6);
    chk("r_exec_aluop", ALU_op, exp_op); tick;
    chk("r_wb_done", instr_done, 1); tick;
  endtask

  initial begin
    rst = 1'b1;
    drive(6'h00, 6'h20, 1'b0, 1'b0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_memread", MemRead, 1);
    chk("fetch_stall_irw", IRWrite, 0);
    chk("fetch_stall_pcw", PCWrite, 0);
    tick;
    chk("fetch_stall_hold", state, 0);

    // add
    drive(6'h00, 6'h20, 1'b1, 1'b0);
    chk("add_fetch_irw", IRWrite, 1);
    chk("add_fetch_pcw", PCWrite, 1);
    chk("add_fetch_srcb", ALUSrcB, 1);
    tick;
    chk("add_dec_state", state, 1);
    chk("add_dec_srcb", ALUSrcB, 3);
    chk("add_dec_done", instr_done, 0);
    tick;
    chk("add_exec_state", state, 6);
    chk("add_exec_aluop", ALU_op, 0);
    chk("add_exec_srca", ALUSrcA, 1);
    tick;
    chk("add_wb_state", state, 7);
    chk("add_wb_regw", RegWrite, 1);
    chk("add_wb_dest", RegDest, 1);
    chk("add_wb_done", instr_done, 1);
    tick;
    chk("add_back_fetch", state, 0);

    run_r(6'h22, 6);
    run_r(6'h27, 10);
    run_r(6'h00, 3);
    run_r(6'h2A, 5);

    // lw with two wait cycles in MEM_READ
    drive(6'h23, 6'h00, 1'b1, 1'b0); tick;
    chk("lw_dec", state, 1); tick;
    chk("lw_addr_state", state, 2);
    chk("lw_addr_srcb", ALUSrcB, 2); tick;
    drive(6'h23, 6'h00, 1'b0, 1'b0);
    chk("lw_rd1_state", state, 3);
    chk("lw_rd1_memread", MemRead, 1);
    chk("lw_rd1_iord", IorD, 1); tick;
    chk("lw_rd2_state", state, 3);
    chk("lw_rd2_iord", IorD, 1);
    chk("lw_rd2_byte", mem_byte, 0); tick;
    drive(6'h23, 6'h00, 1'b1, 1'b0);
    chk("lw_rd3_state", state, 3); tick;
    chk("lw_wb_state", state, 4);
    chk("lw_wb_regw", RegWrite, 1);
    chk("lw_wb_m2r", MemtoReg, 1);
    chk("lw_wb_done", instr_done, 1); tick;

    // beq taken, bne not taken (zero = 1)
    drive(6'h04, 6'h00, 1'b1, 1'b1); tick; tick;
    chk("beq_state", state, 8);
    chk("beq_pcw", PCWrite, 1);
    chk("beq_pcsrc", PCSource, 1);
    chk("beq_aluop", ALU_op, 9);
    chk("beq_done", instr_done, 1); tick;
    drive(6'h05, 6'h00, 1'b1, 1'b1); tick; tick;
    chk("bne_pcw", PCWrite, 0);
    chk("bne_aluop", ALU_op, 8); tick;

    // jal then jr
    drive(6'h03, 6'h00, 1'b1, 1'b0); tick; tick;
    chk("jal_state", state, 9);
    chk("jal_dest", RegDest, 2);
    chk("jal_m2r", MemtoReg, 2);
    chk("jal_pcsrc", PCSource, 2);
    chk("jal_regw", RegWrite, 1); tick;
    drive(6'h00, 6'h08, 1'b1, 1'b0);
    chk("jr_f_regw", RegWrite, 0); tick;
    chk("jr_dec_state", state, 1);
    chk("jr_dec_regw", RegWrite, 0); tick;
    chk("jr_state", state, 12);
    chk("jr_pcsrc", PCSource, 3);
    chk("jr_pcw", PCWrite, 1);
    chk("jr_regw", RegWrite, 0); tick;

    // andi
    drive(6'h0C, 6'h00, 1'b1, 1'b0); tick; tick;
    chk("andi_state", state, 10);
    chk("andi_aluop", ALU_op, 1);
    chk("andi_ext", ExtZero, 1); tick;
    chk("andi_wb_dest", RegDest, 0);
    chk("andi_wb_regw", RegWrite, 1); tick;

    // illegal opcode
    drive(6'h3F, 6'h00, 1'b1, 1'b0); tick;
    chk("ill_op", illegal_op, 1);
    chk("ill_done", instr_done, 1);
    chk("ill_regw", RegWrite, 0);
    chk("ill_memw", MemWrite, 0);
    chk("ill_pcw", PCWrite, 0); tick;
    chk("ill_next_state", state, 0);

    // sb waiting on memory, then reset mid-write
    drive(6'h28, 6'h00, 1'b1, 1'b0); tick; tick;
    drive(6'h28, 6'h00, 1'b0, 1'b0); tick;
    chk("sb_state", state, 5);
    chk("sb_memw", MemWrite, 1);
    chk("sb_byte", mem_byte, 1);
    chk("sb_wait_done", instr_done, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_memw", MemWrite, 0);
    chk("rst_mid_iord", IorD, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rst_after_state", state, 0);
    chk("rst_after_memread", MemRead, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
